// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/load result arbiter feeding the register-file write port
module regfile_wb_arbiter #(
   parameter int XLEN  = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            wb_stall,
   output logic            we,
   output logic [AW-1:0]   rd,
   output logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   q_rs1,
   input  logic [AW-1:0]   q_rs2,
   output logic            q_hit1,
   output logic [XLEN-1:0] q_data1,
   output logic            q_hit2,
   output logic [XLEN-1:0] q_data2,
   output logic            empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE_FREE = CW'(DEPTH - 1);

   logic [AW-1:0]   fifo_rd   [DEPTH];
   logic [XLEN-1:0] fifo_data [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;
   logic            rr_mem;       // 0: ALU wins the last free slot, 1: load wins

   logic            one_free;
   logic            two_free;
   logic            alu_fire;
   logic            mem_fire;
   logic            push_alu;
   logic            push_mem;
   logic            pop;
   logic [PW-1:0]   alu_slot;
   logic [PW-1:0]   slot;

   assign one_free = (count == CNT_ONE_FREE);
   assign two_free = (count < CNT_ONE_FREE);
   assign alu_fire = alu_valid && alu_ready;
   assign mem_fire = mem_valid && mem_ready;
   assign push_alu = alu_fire && (alu_rd != '0);
   assign push_mem = mem_fire && (mem_rd != '0);
   assign pop      = !wb_stall && (count != '0);
   // the load entry is older, so on a dual push the ALU entry lands one slot later
   assign alu_slot = tail + PW'(push_mem);
   assign empty    = (count == '0) && !we;

   // grant logic: free space is judged on the current count only, a same-cycle pop never helps
   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      if (two_free) begin
         alu_ready = 1'b1;
         mem_ready = 1'b1;
      end else if (one_free) begin
         if (alu_valid && mem_valid) begin
            alu_ready = !rr_mem;
            mem_ready = rr_mem;
         end else if (mem_valid) begin
            mem_ready = 1'b1;
         end else if (alu_valid) begin
            alu_ready = 1'b1;
         end else begin
            alu_ready = !rr_mem;
            mem_ready = rr_mem;
         end
      end
   end

   // queue pointers, occupancy and round-robin state
   always_ff @(posedge clk) begin
      if (rst) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         rr_mem <= 1'b0;
      end else begin
         tail  <= tail + PW'(push_mem) + PW'(push_alu);
         if (pop)
            head <= head + PW'(1'b1);
         count <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
         // contention for the last slot: the loser gets priority next time
         if (one_free && alu_valid && mem_valid)
            rr_mem <= !rr_mem;
      end
   end

   // queue storage; contents are meaningless outside head..tail so no reset is needed
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (push_mem) begin
            fifo_rd[tail]   <= mem_rd;
            fifo_data[tail] <= mem_data;
         end
         if (push_alu) begin
            fifo_rd[alu_slot]   <= alu_rd;
            fifo_data[alu_slot] <= alu_data;
         end
      end
   end

   // write-port register: pops the head when the port is free, holds everything while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         we <= 1'b0;
         rd <= '0;
         wd <= '0;
      end else if (!wb_stall) begin
         we <= (count != '0);
         if (count != '0) begin
            rd <= fifo_rd[head];
            wd <= fifo_data[head];
         end
      end
   end

   // bypass lookup, scanned oldest to youngest so the last match is the youngest write
   always_comb begin
      q_hit1  = 1'b0;
      q_data1 = '0;
      q_hit2  = 1'b0;
      q_data2 = '0;
      slot    = '0;
      if (we && (rd == q_rs1) && (q_rs1 != '0)) begin
         q_hit1  = 1'b1;
         q_data1 = wd;
      end
      if (we && (rd == q_rs2) && (q_rs2 != '0)) begin
         q_hit2  = 1'b1;
         q_data2 = wd;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            slot = head + PW'(i);
            if ((fifo_rd[slot] == q_rs1) && (q_rs1 != '0)) begin
               q_hit1  = 1'b1;
               q_data1 = fifo_data[slot];
            end
            if ((fifo_rd[slot] == q_rs2) && (q_rs2 != '0)) begin
               q_hit2  = 1'b1;
               q_data2 = fifo_data[slot];
            end
         end
      end
   end

`ifndef SYNTHESIS
   // occupancy can never exceed the queue size
   always_ff @(posedge clk) begin
      if (!rst)
         assert (count <= CNT_FULL);
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        wb_stall;
   logic        we;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic [4:0]  q_rs1;
   logic [4:0]  q_rs2;
   logic        q_hit1;
   logic [31:0] q_data1;
   logic        q_hit2;
   logic [31:0] q_data2;
   logic        empty;

   int n_cmp = 0;
   int n_err = 0;

   regfile_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .wb_stall  (wb_stall),
      .we        (we),
      .rd        (rd),
      .wd        (wd),
      .q_rs1     (q_rs1),
      .q_rs2     (q_rs2),
      .q_hit1    (q_hit1),
      .q_data1   (q_data1),
      .q_hit2    (q_hit2),
      .q_data2   (q_data2),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input string tag, input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_wd);
      check({tag, ".we"}, 64'(we), 64'(e_we));
      check({tag, ".rd"}, 64'(rd), 64'(e_rd));
      check({tag, ".wd"}, 64'(wd), 64'(e_wd));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [4:0]  exp_rd [7];
      logic [31:0] exp_wd [7];

      rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      wb_stall = 1'b0; q_rs1 = '0; q_rs2 = '0;

      // reset
      tick(); tick();
      check_wr("reset", 1'b0, 5'd0, 32'h0);
      check("reset.empty", 64'(empty), 64'd1);
      check("reset.alu_ready", 64'(alu_ready), 64'd1);
      check("reset.mem_ready", 64'(mem_ready), 64'd1);
      rst = 1'b0;

      // single ALU write
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAA_AAAA;
      #1 check("t1.alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0; q_rs1 = 5'd1;
      #1;
      check("t1.we_accept_edge", 64'(we), 64'd0);
      check("t1.empty_queued", 64'(empty), 64'd0);
      check("t1.hit_queued", 64'(q_hit1), 64'd1);
      check("t1.data_queued", 64'(q_data1), 64'hAAAA_AAAA);
      tick();
      check_wr("t1.write", 1'b1, 5'd1, 32'hAAAA_AAAA);
      check("t1.hit_outreg", 64'(q_hit1), 64'd1);
      tick();
      check("t1.we_after", 64'(we), 64'd0);
      check("t1.empty_after", 64'(empty), 64'd1);
      check("t1.hit_after", 64'(q_hit1), 64'd0);
      check("t1.data_after", 64'(q_data1), 64'd0);

      // dual accept, load entry older
      mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h1234_5678;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1;
      check("t2.alu_ready", 64'(alu_ready), 64'd1);
      check("t2.mem_ready", 64'(mem_ready), 64'd1);
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0; q_rs1 = 5'd5;
      #1;
      check("t2.hit_both_queued", 64'(q_hit1), 64'd1);
      check("t2.data_both_queued", 64'(q_data1), 64'hDEAD_BEEF);
      tick();
      check_wr("t2.write_mem", 1'b1, 5'd5, 32'h1234_5678);
      check("t2.data_youngest", 64'(q_data1), 64'hDEAD_BEEF);
      tick();
      check_wr("t2.write_alu", 1'b1, 5'd5, 32'hDEAD_BEEF);
      tick();
      check("t2.we_after", 64'(we), 64'd0);
      check("t2.empty_after", 64'(empty), 64'd1);
      check("t2.hit_after", 64'(q_hit1), 64'd0);

      // x0 discard
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF; q_rs1 = 5'd0;
      #1 check("t3.alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      #1;
      check("t3.we", 64'(we), 64'd0);
      check("t3.empty", 64'(empty), 64'd1);
      check("t3.hit_x0", 64'(q_hit1), 64'd0);
      tick();
      check("t3.we_later", 64'(we), 64'd0);
      check("t3.empty_later", 64'(empty), 64'd1);

      // full queue and round-robin on the last slot
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(i);
         #1 check("t4.fill_ready", 64'(alu_ready), 64'd1);
         tick();
      end
      alu_rd = 5'd13; alu_data = 32'h200;
      mem_valid = 1'b1; mem_rd = 5'd14; mem_data = 32'h300;
      #1;
      check("t4.rr1_alu_ready", 64'(alu_ready), 64'd1);
      check("t4.rr1_mem_ready", 64'(mem_ready), 64'd0);
      tick();
      alu_rd = 5'd15; alu_data = 32'h201;
      #1;
      check("t4.full_alu_ready", 64'(alu_ready), 64'd0);
      check("t4.full_mem_ready", 64'(mem_ready), 64'd0);
      tick();
      check("t4.stalled_we", 64'(we), 64'd0);
      wb_stall = 1'b0;
      #1;
      check("t4.nopass_alu_ready", 64'(alu_ready), 64'd0);
      check("t4.nopass_mem_ready", 64'(mem_ready), 64'd0);
      exp_rd[0] = 5'd10; exp_wd[0] = 32'h100;
      exp_rd[1] = 5'd11; exp_wd[1] = 32'h101;
      exp_rd[2] = 5'd12; exp_wd[2] = 32'h102;
      exp_rd[3] = 5'd13; exp_wd[3] = 32'h200;
      exp_rd[4] = 5'd14; exp_wd[4] = 32'h300;
      exp_rd[5] = 5'd15; exp_wd[5] = 32'h201;
      exp_rd[6] = 5'd16; exp_wd[6] = 32'h301;
      tick();
      check_wr("t4.drain0", 1'b1, exp_rd[0], exp_wd[0]);
      check("t4.rr2_alu_ready", 64'(alu_ready), 64'd0);
      check("t4.rr2_mem_ready", 64'(mem_ready), 64'd1);
      tick();
      check_wr("t4.drain1", 1'b1, exp_rd[1], exp_wd[1]);
      mem_rd = 5'd16; mem_data = 32'h301;
      #1;
      check("t4.rr3_alu_ready", 64'(alu_ready), 64'd1);
      check("t4.rr3_mem_ready", 64'(mem_ready), 64'd0);
      tick();
      check_wr("t4.drain2", 1'b1, exp_rd[2], exp_wd[2]);
      alu_valid = 1'b0;
      #1 check("t4.single_mem_ready", 64'(mem_ready), 64'd1);
      tick();
      mem_valid = 1'b0;
      for (int i = 3; i < 7; i++) begin
         check_wr($sformatf("t4.drain%0d", i), 1'b1, exp_rd[i], exp_wd[i]);
         tick();
      end
      check("t4.we_done", 64'(we), 64'd0);
      check("t4.empty_done", 64'(empty), 64'd1);

      // stall holds a presented write
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55;
      tick();
      alu_rd = 5'd4; alu_data = 32'h66;
      tick();
      alu_valid = 1'b0; wb_stall = 1'b1;
      check_wr("t5.presented", 1'b1, 5'd3, 32'h55);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_wr($sformatf("t5.hold%0d", i), 1'b1, 5'd3, 32'h55);
      end
      wb_stall = 1'b0;
      tick();
      check_wr("t5.next", 1'b1, 5'd4, 32'h66);
      tick();
      check("t5.we_done", 64'(we), 64'd0);

      // reset in the middle of traffic
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
      tick();
      alu_rd = 5'd8; alu_data = 32'h80;
      tick();
      wb_stall = 1'b1;
      alu_rd = 5'd9; alu_data = 32'h90;
      tick();
      alu_rd = 5'd10; alu_data = 32'hA0;
      tick();
      alu_valid = 1'b0; q_rs1 = 5'd9; q_rs2 = 5'd7;
      #1;
      check_wr("t6.before", 1'b1, 5'd7, 32'h70);
      check("t6.hit1_before", 64'(q_data1), 64'h90);
      check("t6.hit2_before", 64'(q_data2), 64'h70);
      rst = 1'b1;
      tick();
      check_wr("t6.reset", 1'b0, 5'd0, 32'h0);
      check("t6.empty", 64'(empty), 64'd1);
      check("t6.hit1", 64'(q_hit1), 64'd0);
      check("t6.hit2", 64'(q_hit2), 64'd0);
      rst = 1'b0; wb_stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t6.no_write%0d", i), 64'(we), 64'd0);
      end
      check("t6.empty_after", 64'(empty), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
